// File: rtl/encode_job_ctrl.sv
// ---------------------------------------------------------------------------
// encode_job_ctrl
//
// Per-job sequencer between the LZS code generator and the 16-bit output
// packer. It passes codes straight through to the packer, appends the LZS
// end marker, pads the stream to a 16-bit boundary, and raises the packer
// finish request. It then waits for the packer's done pulse and reports the
// job's word count and overflow status.
//
// Build option:
//   ENCODE_CTRL_EMARK_EN  defined   -> end marker (EMARK_CODE/EMARK_LEN) is
//                                       appended before padding.
//                         undefined -> the stream ends with padding only.
//
// Parameters:
//   LIMIT_W     width of job_limit / job_words
//   DRAIN_CYC   idle cycles after the last pk_en before pk_finish is raised
//   EMARK_CODE  end-marker pattern, right-aligned
//   EMARK_LEN   end-marker bit length
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   job_start/job_limit     start pulse (sampled in IDLE) and word limit (0 = none)
//   job_busy/job_done       busy level, 1-cycle completion pulse
//   job_words/job_ovf       words emitted this job, sticky overflow flag
//   core_code/len/valid/last, core_ready   code input handshake
//   pk_code/len/en/finish   packer drive
//   pk_valid/pk_done        packer word-written and done indications
// ---------------------------------------------------------------------------
module encode_job_ctrl #(
  parameter int unsigned LIMIT_W    = 16,
  parameter int unsigned DRAIN_CYC  = 3,
  parameter logic [12:0] EMARK_CODE = 13'h180,
  parameter logic [3:0]  EMARK_LEN  = 4'd9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_start,
  input  logic [LIMIT_W-1:0] job_limit,
  output logic               job_busy,
  output logic               job_done,
  output logic [LIMIT_W-1:0] job_words,
  output logic               job_ovf,
  input  logic [12:0]        core_code,
  input  logic [3:0]         core_len,
  input  logic               core_valid,
  input  logic               core_last,
  output logic               core_ready,
  output logic [12:0]        pk_code,
  output logic [3:0]         pk_len,
  output logic               pk_en,
  output logic               pk_finish,
  input  logic               pk_valid,
  input  logic               pk_done
);

  localparam int unsigned DCW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_EMARK,
    S_PAD,
    S_DRAIN,
    S_FIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LIMIT_W-1:0] limit_q, limit_d;
  logic [LIMIT_W-1:0] words_q, words_d;
  logic               ovf_q, ovf_d;
  logic [3:0]         pend_q, pend_d;
  logic [DCW-1:0]     drain_q, drain_d;

  logic               busy;
  logic               at_limit;
  logic               ovf_hit;
  logic [3:0]         pad;

  assign busy     = (state_q != S_IDLE);
  assign at_limit = (limit_q != '0) && (words_q == limit_q);
  // A packer word arriving while already at the limit is the overflow event.
  assign ovf_hit  = busy && pk_valid && at_limit;
  // Bits needed to reach the next 16-bit boundary; 4-bit wrap gives 0 when aligned.
  assign pad      = 4'd0 - pend_q;

  assign job_busy  = busy;
  assign job_words = words_q;
  assign job_ovf   = ovf_q;

  // Word counter and sticky overflow flag.
  always_comb begin
    words_d = words_q;
    ovf_d   = ovf_q;
    if ((state_q == S_IDLE) && job_start) begin
      words_d = '0;
      ovf_d   = 1'b0;
    end else if (ovf_hit) begin
      ovf_d   = 1'b1;
    end else if (busy && pk_valid && (words_q != '1)) begin
      words_d = words_q + LIMIT_W'(1);
    end
  end

  // Next-state and packer/handshake outputs.
  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    pend_d     = pend_q;
    drain_d    = '0;
    core_ready = 1'b0;
    pk_code    = '0;
    pk_len     = '0;
    pk_en      = 1'b0;
    pk_finish  = 1'b0;
    job_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          limit_d = job_limit;
          pend_d  = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (ovf_hit) begin
          // Limit exceeded: stop accepting codes and skip marker/padding.
          state_d = S_DRAIN;
        end else begin
          core_ready = 1'b1;
          pk_code    = core_code;
          pk_len     = core_len;
          pk_en      = core_valid;
          if (core_valid) begin
            pend_d = pend_q + core_len;
            if (core_last) begin
`ifdef ENCODE_CTRL_EMARK_EN
              state_d = S_EMARK;
`else
              state_d = S_PAD;
`endif
            end
          end
        end
      end

      // Only reachable when the end marker is enabled.
      S_EMARK: begin
        pk_code = EMARK_CODE;
        pk_len  = EMARK_LEN;
        pk_en   = 1'b1;
        pend_d  = pend_q + EMARK_LEN;
        state_d = S_PAD;
      end

      S_PAD: begin
        if (pad != 4'd0) begin
          pk_len = pad;
          pk_en  = 1'b1;
        end
        pend_d  = '0;
        state_d = S_DRAIN;
      end

      S_DRAIN: begin
        if (drain_q == DCW'(DRAIN_CYC - 1)) begin
          state_d = S_FIN;
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end

      S_FIN: begin
        pk_finish = 1'b1;
        if (pk_done) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        job_done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      limit_q <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      drain_q <= drain_d;
    end
  end

endmodule
